// File: rtl/reg_bank_reader.sv
// reg_bank_reader
//
// Read side of the MIPS register file for a multicycle datapath: a 32 x 32-bit
// register bank plus a small operand-fetch FSM. The write port takes the
// already-selected write-back address (rt, rd, $ra or third source). rs/rt are
// decoded from the instruction word and delivered as registered operands A/B
// with a start/valid handshake.
//
// Ports
//   clk         rising-edge clock
//   reset_n     synchronous active-low reset (clears bank, operands, indices)
//   rd_start    pulse: begin operand fetch for instr (ignored while rd_busy)
//   instr       instruction word; rs = [25:21], rt = [20:16]
//   rd_busy     fetch in progress
//   rd_valid    one-cycle pulse: a_out/b_out hold new operands
//   a_out       operand A (value of rs)
//   b_out       operand B (value of rt)
//   rs_idx      latched rs index
//   rt_idx      latched rt index
//   reg_write   write enable
//   write_reg   write address
//   write_data  write-back value
//
// Build option
//   REG_BYPASS_EN  when defined, a write landing on the FETCH edge to the
//                  register being fetched is forwarded to the operand.
//
// State | meaning
// ------+---------------------------------------------------
// IDLE  | waiting for rd_start; indices latched on accept
// FETCH | operands loaded from the bank at this edge
// DONE  | rd_valid high for this cycle, then back to IDLE

module reg_bank_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_start,
    input  logic [31:0]       instr,
    output logic              rd_busy,
    output logic              rd_valid,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ADDR_W-1:0] rs_idx,
    output logic [ADDR_W-1:0] rt_idx,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data
);

    localparam int NUM_REGS = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic              write_en;

    // Only the register fields of the instruction are used here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31:26], instr[15:0]};

    // Address 0 is never written, so it keeps its reset value of zero.
    assign write_en = reg_write && (write_reg != '0);

`ifdef REG_BYPASS_EN
    assign operand_a = (write_en && (write_reg == rs_idx)) ? write_data : regs[rs_idx];
    assign operand_b = (write_en && (write_reg == rt_idx)) ? write_data : regs[rt_idx];
`else
    assign operand_a = regs[rs_idx];
    assign operand_b = regs[rt_idx];
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // Reset wins over everything, including a write in the same cycle.
            state    <= IDLE;
            rd_busy  <= 1'b0;
            rd_valid <= 1'b0;
            a_out    <= '0;
            b_out    <= '0;
            rs_idx   <= '0;
            rt_idx   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (write_en) begin
                regs[write_reg] <= write_data;
            end

            rd_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (rd_start) begin
                        rs_idx  <= instr[25:21];
                        rt_idx  <= instr[20:16];
                        rd_busy <= 1'b1;
                        state   <= FETCH;
                    end
                end
                FETCH: begin
                    a_out    <= operand_a;
                    b_out    <= operand_b;
                    rd_valid <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    rd_busy <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    rd_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_reader.sv
// Directed testbench for reg_bank_reader. Inputs are driven and outputs
// sampled 1 ns after each rising edge.
module tb_reg_bank_reader;

    logic        clk;
    logic        reset_n;
    logic        rd_start;
    logic [31:0] instr;
    logic        rd_busy;
    logic        rd_valid;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;

    int vectors;
    int miscompares;
    int valid_count;

    reg_bank_reader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_start   (rd_start),
        .instr      (instr),
        .rd_busy    (rd_busy),
        .rd_valid   (rd_valid),
        .a_out      (a_out),
        .b_out      (b_out),
        .rs_idx     (rs_idx),
        .rt_idx     (rt_idx),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        reg_write  = 1'b1;
        write_reg  = addr;
        write_data = data;
        tick();
        reg_write  = 1'b0;
    endtask

    // Full fetch with handshake checks; leaves the FSM back in IDLE.
    task automatic do_fetch(input logic [4:0] rs, input logic [4:0] rt);
        rd_start = 1'b1;
        instr    = {6'h23, rs, rt, 16'h1234};
        tick();                                  // edge N
        rd_start = 1'b0;
        check("fetch_busy_n",   {31'b0, rd_busy},  32'd1);
        check("fetch_valid_n",  {31'b0, rd_valid}, 32'd0);
        check("fetch_rs_idx",   {27'b0, rs_idx},   {27'b0, rs});
        check("fetch_rt_idx",   {27'b0, rt_idx},   {27'b0, rt});
        tick();                                  // edge N+1
        check("fetch_valid_n1", {31'b0, rd_valid}, 32'd1);
        check("fetch_busy_n1",  {31'b0, rd_busy},  32'd1);
        tick();                                  // edge N+2
        check("fetch_valid_n2", {31'b0, rd_valid}, 32'd0);
        check("fetch_busy_n2",  {31'b0, rd_busy},  32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        rd_start    = 1'b0;
        instr       = '0;
        reg_write   = 1'b0;
        write_reg   = '0;
        write_data  = '0;

        // Reset for 2 cycles
        tick();
        tick();
        check("rst_busy",  {31'b0, rd_busy},  32'd0);
        check("rst_valid", {31'b0, rd_valid}, 32'd0);
        check("rst_a",     a_out, 32'd0);
        check("rst_b",     b_out, 32'd0);
        check("rst_rs",    {27'b0, rs_idx}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Reset then read
        do_fetch(5'd5, 5'd9);
        check("rr_a", a_out, 32'h0);
        check("rr_b", b_out, 32'h0);

        // Write / read
        do_write(5'd5, 32'hDEADBEEF);
        do_write(5'd9, 32'h00000042);
        do_fetch(5'd5, 5'd9);
        check("wr_a", a_out, 32'hDEADBEEF);
        check("wr_b", b_out, 32'h00000042);

        // rs == rt
        do_fetch(5'd9, 5'd9);
        check("same_a", a_out, 32'h00000042);
        check("same_b", b_out, 32'h00000042);

        // $zero protection
        do_write(5'd0, 32'hFFFFFFFF);
        do_fetch(5'd0, 5'd0);
        check("zero_a", a_out, 32'h0);
        check("zero_b", b_out, 32'h0);

        // $ra path
        do_write(5'd31, 32'h00400018);
        do_fetch(5'd31, 5'd5);
        check("ra_a", a_out, 32'h00400018);
        check("ra_b", b_out, 32'hDEADBEEF);

        // Coinciding write at the FETCH edge
        do_write(5'd8, 32'h1);
        rd_start = 1'b1;
        instr    = {6'h0, 5'd8, 5'd0, 16'h0};
        tick();                                  // edge N: now in FETCH
        rd_start   = 1'b0;
        reg_write  = 1'b1;
        write_reg  = 5'd8;
        write_data = 32'h2;
        tick();                                  // edge N+1: FETCH edge + write
        reg_write  = 1'b0;
        check("coin_valid", {31'b0, rd_valid}, 32'd1);
`ifdef REG_BYPASS_EN
        check("coin_a", a_out, 32'h2);
`else
        check("coin_a", a_out, 32'h1);
`endif
        tick();
        do_fetch(5'd8, 5'd0);
        check("coin_later_a", a_out, 32'h2);

        // rd_start held through FETCH and DONE: only one rd_valid
        valid_count = 0;
        rd_start = 1'b1;
        instr    = {6'h0, 5'd9, 5'd5, 16'h0};
        tick();                                  // accepted
        instr    = {6'h0, 5'd31, 5'd31, 16'h0};  // must not be picked up
        for (int i = 0; i < 6; i++) begin
            if (i == 2) rd_start = 1'b0;
            tick();
            if (rd_valid) valid_count++;
        end
        check("busy_valid_cnt", valid_count, 32'd1);
        check("busy_a", a_out, 32'h00000042);
        check("busy_b", b_out, 32'hDEADBEEF);
        check("busy_rs", {27'b0, rs_idx}, 32'd9);

        // Reset during FETCH aborts, and the coinciding write is discarded
        rd_start = 1'b1;
        instr    = {6'h0, 5'd5, 5'd9, 16'h0};
        tick();                                  // now in FETCH
        rd_start   = 1'b0;
        reset_n    = 1'b0;
        reg_write  = 1'b1;
        write_reg  = 5'd7;
        write_data = 32'h77;
        tick();
        reset_n   = 1'b1;
        reg_write = 1'b0;
        check("abort_valid", {31'b0, rd_valid}, 32'd0);
        check("abort_busy",  {31'b0, rd_busy},  32'd0);
        check("abort_a",     a_out, 32'h0);
        check("abort_b",     b_out, 32'h0);
        valid_count = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rd_valid) valid_count++;
        end
        check("abort_no_valid", valid_count, 32'd0);
        do_fetch(5'd7, 5'd5);
        check("abort_w7_a", a_out, 32'h0);
        check("abort_r5_b", b_out, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
